// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops plus iterative shift-add MUL and restoring DIV.
// Optional feature: define ALU_DIV0_TRAP_EN to trap DIV by zero as a 1-cycle op with div_by_zero flagged.
module alu_exec #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             illegal_op
);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_MUL  = 2'b01;
    localparam logic [1:0] S_DIV  = 2'b10;
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b, r_lo, r_hi;
    logic             r_pend;
    logic [WIDTH-1:0] r_result, r_result_hi;
    logic             r_done, r_zero, r_overflow, r_dbz, r_illegal;

    // Single-cycle datapath works from the operands latched at accept.
    logic [WIDTH-1:0] w_sum, w_diff, w_nb, w_res, w_hi;
    logic             w_ovf, w_ill, w_dbz;

    assign w_sum  = r_a + r_b;
    assign w_nb   = ~r_b + 1'b1;
    assign w_diff = r_a + w_nb;

    always_comb begin
        w_res = '0;
        w_hi  = '0;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        w_dbz = 1'b0;
        case (r_op)
            4'b0000: begin
                w_res = w_sum;
                w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            4'b0001: begin
                w_res = w_diff;
                w_ovf = (r_a[WIDTH-1] == w_nb[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            4'b0010: ;
            4'b0011: begin
`ifdef ALU_DIV0_TRAP_EN
                w_res = '1;
                w_hi  = r_a;
                w_dbz = 1'b1;
`endif
            end
            4'b0100: w_res = r_a & r_b;
            4'b0101: begin
                w_res = r_b;
                w_hi  = r_a;
            end
            4'b0111: w_res = r_a | r_b;
            4'b1000: w_res = w_sum;
            default: w_ill = 1'b1;
        endcase
    end

    // One shift-add multiply step: {hi,lo} holds partial product over the remaining multiplier bits.
    logic [WIDTH:0]   w_madd;
    logic [WIDTH-1:0] w_mul_hi, w_mul_lo;
    assign w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_mul_hi = w_madd[WIDTH:1];
    assign w_mul_lo = {w_madd[0], r_lo[WIDTH-1:1]};

    // One restoring divide step: hi is the partial remainder, lo shifts dividend out and quotient in.
    logic [WIDTH:0]   w_shift, w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_div_hi, w_div_lo;
    assign w_shift  = {r_hi, r_lo[WIDTH-1]};
    assign w_ge     = w_shift >= {1'b0, r_b};
    assign w_sub    = w_shift - {1'b0, r_b};
    assign w_div_hi = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_div_lo = {r_lo[WIDTH-2:0], w_ge};

    logic w_div0;
`ifdef ALU_DIV0_TRAP_EN
    assign w_div0 = (b == '0);
`else
    assign w_div0 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_lo        <= '0;
            r_hi        <= '0;
            r_pend      <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_done      <= 1'b0;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_dbz       <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_pend <= 1'b0;
            if (r_pend) begin
                r_result    <= w_res;
                r_result_hi <= w_hi;
                r_zero      <= (w_res == '0);
                r_overflow  <= w_ovf;
                r_dbz       <= w_dbz;
                r_illegal   <= w_ill;
                r_done      <= 1'b1;
            end
            case (r_state)
                S_MUL, S_DIV: begin
                    r_hi  <= (r_state == S_MUL) ? w_mul_hi : w_div_hi;
                    r_lo  <= (r_state == S_MUL) ? w_mul_lo : w_div_lo;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state     <= S_IDLE;
                        r_result    <= (r_state == S_MUL) ? w_mul_lo : w_div_lo;
                        r_result_hi <= (r_state == S_MUL) ? w_mul_hi : w_div_hi;
                        r_zero      <= ((r_state == S_MUL) ? w_mul_lo : w_div_lo) == '0;
                        r_overflow  <= 1'b0;
                        r_dbz       <= 1'b0;
                        r_illegal   <= 1'b0;
                        r_done      <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        r_op <= operation;
                        r_a  <= a;
                        r_b  <= b;
                        r_lo <= a;
                        r_hi <= '0;
                        if (operation == 4'b0010) begin
                            r_state <= S_MUL;
                            r_cnt   <= CW'(WIDTH);
                        end else if (operation == 4'b0011 && !w_div0) begin
                            r_state <= S_DIV;
                            r_cnt   <= CW'(WIDTH);
                        end else begin
                            r_pend <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign result      = r_result;
    assign result_hi   = r_result_hi;
    assign zero        = r_zero;
    assign overflow    = r_overflow;
    assign div_by_zero = r_dbz;
    assign illegal_op  = r_illegal;
endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector bench for alu_exec (WIDTH=16); expected values computed by hand.
module tb_alu_exec;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [3:0]  operation;
    logic [15:0] a, b;
    logic        busy, done, zero, overflow, div_by_zero, illegal_op;
    logic [15:0] result, result_hi;

    int n_checks = 0;
    int n_errors = 0;

    alu_exec #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .operation(operation), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .result_hi(result_hi), .zero(zero),
        .overflow(overflow), .div_by_zero(div_by_zero), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits for done (bounded); returns cycles counted from the accept edge.
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            cycles++;
            if (done) return;
        end
        cycles = -1;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] va, input logic [15:0] vb,
                          input int exp_cyc, input logic [15:0] exp_res, input logic [15:0] exp_hi,
                          input logic exp_z, input logic exp_ov, input logic exp_dz, input logic exp_il);
        int cyc;
        @(negedge clk);
        operation = op; a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc);
        check({tag, " cycles"}, cyc, exp_cyc);
        check({tag, " result"}, result, exp_res);
        check({tag, " hi"}, result_hi, exp_hi);
        check({tag, " flags"}, {zero, overflow, div_by_zero, illegal_op}, {exp_z, exp_ov, exp_dz, exp_il});
        @(posedge clk); #1;
        check({tag, " done pulse"}, done, 1'b0);
        $display("op %b a=%h b=%h -> res=%h hi=%h z=%b ov=%b dz=%b il=%b cyc=%0d",
                 op, va, vb, result, result_hi, zero, overflow, div_by_zero, illegal_op, cyc);
    endtask

    initial begin
        int cyc;
        logic saw_done;
        rst = 1'b1; start = 1'b0; operation = 4'h0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset outputs", {busy, done, zero, overflow, div_by_zero, illegal_op}, 6'b0);
        check("reset result", {result, result_hi}, 32'h0);

        run_op("ADD ovf", 4'b0000, 16'h7FFF, 16'h0001, 1, 16'h8000, 16'h0000, 0, 1, 0, 0);
        run_op("SUB ovf", 4'b0001, 16'h8000, 16'h0001, 1, 16'h7FFF, 16'h0000, 0, 1, 0, 0);
        run_op("ADDR", 4'b1000, 16'h7FFF, 16'h0001, 1, 16'h8000, 16'h0000, 0, 0, 0, 0);
        run_op("AND", 4'b0100, 16'hF0F0, 16'h3C3C, 1, 16'h3030, 16'h0000, 0, 0, 0, 0);
        run_op("OR", 4'b0111, 16'hF000, 16'h000F, 1, 16'hF00F, 16'h0000, 0, 0, 0, 0);
        run_op("ILLEGAL", 4'b0110, 16'h1111, 16'h2222, 1, 16'h0000, 16'h0000, 1, 0, 0, 1);
        run_op("ILLEGAL F", 4'b1111, 16'h1111, 16'h2222, 1, 16'h0000, 16'h0000, 1, 0, 0, 1);

        // SUB 5-5, then SWAP issued in the cycle done is high
        @(negedge clk);
        operation = 4'b0001; a = 16'd5; b = 16'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("SUB zero done", done, 1'b1);
        check("SUB zero flags", {zero, result}, {1'b1, 16'h0000});
        operation = 4'b0101; a = 16'h1234; b = 16'hABCD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("SWAP b2b gap", done, 1'b0);
        @(posedge clk); #1;
        check("SWAP done", done, 1'b1);
        check("SWAP result", {result, result_hi}, {16'hABCD, 16'h1234});
        check("SWAP zero", zero, 1'b0);
        $display("b2b SUB/SWAP -> res=%h hi=%h", result, result_hi);

        // MUL with a start attempt in the middle of the operation
        @(negedge clk);
        operation = 4'b0010; a = 16'hFFFF; b = 16'h0002; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin
                check("MUL busy", busy, 1'b1);
                operation = 4'b0000; a = 16'h0001; b = 16'h0001; start = 1'b1;
            end
            if (k == 6) start = 1'b0;
            if (done) begin
                cyc = k;
                break;
            end
        end
        check("MUL cycles", cyc, 16);
        check("MUL result", {result_hi, result}, 32'h0001_FFFE);
        check("MUL flags", {zero, overflow, busy}, 3'b000);
        @(posedge clk); #1;
        check("MUL no queued op", done, 1'b0);
        $display("op 0010 a=ffff b=0002 -> res=%h hi=%h cyc=%0d", result, result_hi, cyc);

        run_op("DIV", 4'b0011, 16'd100, 16'd7, 16, 16'd14, 16'd2, 0, 0, 0, 0);

`ifdef ALU_DIV0_TRAP_EN
        run_op("DIV0", 4'b0011, 16'h0123, 16'h0000, 1, 16'hFFFF, 16'h0123, 0, 0, 1, 0);
`else
        run_op("DIV0", 4'b0011, 16'h0123, 16'h0000, 16, 16'hFFFF, 16'h0123, 0, 0, 0, 0);
`endif

        // DIV aborted by a 2-cycle reset at cycle 8
        @(negedge clk);
        operation = 4'b0011; a = 16'd100; b = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("abort busy before rst", busy, 1'b1);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("rst ctl", {busy, done, zero, overflow, div_by_zero, illegal_op}, 6'b0);
            check("rst data", {result, result_hi}, 32'h0);
        end
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("abort no done", saw_done, 1'b0);
        $display("DIV aborted by rst -> busy=%b res=%h", busy, result);

        run_op("post-rst ADD", 4'b0000, 16'h0003, 16'h0004, 1, 16'h0007, 16'h0000, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
